// File: rtl/fetch_stage_pkg.sv
// Shared RV32I types for the front end of the pipeline.
//
// Purpose: word, register-index and opcode types used across stages,
// plus the fetch FSM state encoding and the canonical NOP word that is
// used to fill bubbles in the IF/ID register.
//
// Contents:
//   rv32i_word     32-bit data/address word
//   rv32i_reg      5-bit architectural register index
//   rv32i_opcode   7-bit major opcode enumeration
//   fetch_state_t  FETCH / HOLD / DISCARD
//   NOP_INSTR      addi x0,x0,0
//   nextPc()       sequential pc increment, wraps modulo 2^32
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [4:0]  rv32i_reg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam rv32i_word NOP_INSTR = 32'h0000_0013;

  // Plain 32-bit add; the carry out is dropped so 0xFFFF_FFFC wraps to 0.
  function automatic rv32i_word nextPc(input rv32i_word pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//
// Purpose: holds the valid bit, pc and instruction word handed from fetch
// to decode. Flush inserts a bubble (valid=0, pc=0, ir=NOP) and wins over
// load; with neither asserted the contents are held.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_load            capture i_valid/i_pc/i_ir
//   i_flush           replace contents with a bubble
//   i_valid/i_pc/i_ir incoming entry
//   o_valid/o_pc/o_ir registered entry
module if_id_reg
  import rv32i_types::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_ir,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_ir
);

  logic      r_valid;
  rv32i_word r_pc;
  rv32i_word r_ir;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_ir    <= NOP_INSTR;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_pc    <= i_pc;
      r_ir    <= i_ir;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_ir    = r_ir;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage.
//
// Purpose: issues word-aligned reads to instruction memory, places returned
// words into the IF/ID register, absorbs downstream stalls with a one-entry
// skid buffer and handles EX-stage redirects, including the case where a
// redirect arrives while a read is still outstanding (DISCARD drains it).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_read/imem_address   read request and word address
//   imem_rdata/imem_resp     returned word and one-cycle completion pulse
//   stall_in                 downstream hazard, IF/ID must hold
//   redirect/redirect_pc     taken branch/jump target from EX
//   if_id_valid/pc/ir        IF/ID register contents
//   opcode..rd_id            decoded fields of if_id_ir
//   fetch_stall              fetch is waiting on memory
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_ir,
  output rv32i_opcode opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output rv32i_reg    rs1_id,
  output rv32i_reg    rs2_id,
  output rv32i_reg    rd_id,
  output logic        fetch_stall
);

  fetch_state_t r_state;
  rv32i_word    r_pc;
  rv32i_word    r_reqAddr;
  logic         r_skidValid;
  rv32i_word    r_skidPc;
  rv32i_word    r_skidIr;
  logic         r_postReset;

  logic         w_resp;
  logic         w_loadCond;
  logic         w_load;
  logic         w_flush;
  logic         w_loadValid;
  rv32i_word    w_loadPc;
  rv32i_word    w_loadIr;
  rv32i_word    w_redirectPc;
  logic         w_unusedAddrBits;

  // A response landing in the first cycle after reset belongs to a read
  // issued before reset, so it is masked out.
  assign w_resp = imem_resp && !r_postReset;

  assign w_redirectPc     = {redirect_pc[31:2], 2'b00};
  assign w_unusedAddrBits = ^redirect_pc[1:0];

  // IF/ID takes a fresh word from memory, or the parked skid entry once the
  // stall clears. Without a load and without a stall the slot becomes a
  // bubble; a redirect always forces a bubble.
  assign w_loadCond = !stall_in &&
                      ((r_state == FETCH && w_resp) || r_state == HOLD);
  assign w_load     = !redirect && w_loadCond;
  assign w_flush    = redirect || (!stall_in && !w_loadCond);

  assign w_loadValid = (r_state == HOLD) ? r_skidValid : 1'b1;
  assign w_loadPc    = (r_state == HOLD) ? r_skidPc    : r_pc;
  assign w_loadIr    = (r_state == HOLD) ? r_skidIr    : imem_rdata;

  // Fetch FSM, pc and skid buffer. While draining in DISCARD the request
  // keeps its old address (r_reqAddr) and r_pc already holds the target.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_reqAddr   <= RESET_PC;
      r_skidValid <= 1'b0;
      r_skidPc    <= '0;
      r_skidIr    <= NOP_INSTR;
      r_postReset <= 1'b1;
    end else begin
      r_postReset <= 1'b0;
      if (redirect) begin
        r_pc        <= w_redirectPc;
        r_skidValid <= 1'b0;
        case (r_state)
          FETCH: begin
            if (!w_resp) begin
              r_state   <= DISCARD;
              r_reqAddr <= r_pc;
            end
          end
          DISCARD: r_state <= w_resp ? FETCH : DISCARD;
          default: r_state <= FETCH;
        endcase
      end else begin
        case (r_state)
          FETCH: begin
            if (w_resp) begin
              if (stall_in) begin
                r_skidValid <= 1'b1;
                r_skidPc    <= r_pc;
                r_skidIr    <= imem_rdata;
                r_state     <= HOLD;
              end else begin
                r_pc <= nextPc(r_pc);
              end
            end
          end
          HOLD: begin
            if (!stall_in) begin
              r_skidValid <= 1'b0;
              r_pc        <= nextPc(r_skidPc);
              r_state     <= FETCH;
            end
          end
          DISCARD: begin
            if (w_resp) r_state <= FETCH;
          end
          default: r_state <= FETCH;
        endcase
      end
    end
  end

  assign imem_read    = !rst && (r_state != HOLD);
  assign imem_address = (r_state == DISCARD) ? r_reqAddr : r_pc;
  assign fetch_stall  = !rst && ((r_state == FETCH && imem_read && !w_resp) ||
                                 r_state == DISCARD);

  if_id_reg u_if_id (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_valid (w_loadValid),
    .i_pc    (w_loadPc),
    .i_ir    (w_loadIr),
    .o_valid (if_id_valid),
    .o_pc    (if_id_pc),
    .o_ir    (if_id_ir)
  );

  assign opcode = rv32i_opcode'(if_id_ir[6:0]);
  assign funct3 = if_id_ir[14:12];
  assign funct7 = if_id_ir[31:25];
  assign rs1_id = if_id_ir[19:15];
  assign rs2_id = if_id_ir[24:20];
  assign rd_id  = if_id_ir[11:7];

endmodule
